// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: ROM address/data, redirect request, decode handshake
// and fault reporting. The fetch unit uses the master side.
interface instr_fetch_unit_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;
  logic [63:0] fault_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational ROM, queues
// {pc, word} pairs in order and hands them to decode over valid/ready.
//
// state   | meaning
// S_FETCH | fetching while the PC is in range and aligned and the queue has room
// S_FAULT | halted on a bad PC; queue drains, waits for a redirect
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {S_FETCH, S_FAULT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [63:0]        r_pc;
  logic [63:0]        r_fault_pc;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_q_instr [DEPTH];
  logic [63:0]        r_q_pc    [DEPTH];

  logic w_valid;
  logic w_pop;
  logic w_room;
  logic w_pc_ok;
  logic w_push;
  logic w_fault_go;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && bus.out_ready;
  assign w_room     = (r_count < CNT_W'(DEPTH)) || w_pop;
  // Bound check on the 64-bit sum; wrap-around near 2^64 is deliberately ignored.
  assign w_pc_ok    = (r_pc[1:0] == 2'b00) && ((r_pc + 64'd3) < 64'(MEM_SIZE));
  // Redirect overrides everything, so neither a push nor a fault can happen in its cycle.
  assign w_push     = (r_state == S_FETCH) && !bus.redirect_valid && w_room && w_pc_ok;
  // A full queue with no pop stalls without evaluating the PC at all.
  assign w_fault_go = (r_state == S_FETCH) && !bus.redirect_valid && w_room && !w_pc_ok;

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_instr = w_valid ? r_q_instr[r_head] : 32'd0;
  assign bus.out_pc    = w_valid ? r_q_pc[r_head]    : 64'd0;
  assign bus.fault     = (r_state == S_FAULT);
  assign bus.fault_pc  = r_fault_pc;

  // Next-state selection: redirect always returns to fetch.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid) begin
      w_state_nxt = S_FETCH;
    end else if (w_fault_go) begin
      w_state_nxt = S_FAULT;
    end
  end

  // State, PC, fault PC and queue bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_fault_pc <= 64'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.redirect_valid) begin
        r_pc    <= bus.redirect_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_pc   <= r_pc + 64'd4;
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (!w_push && w_pop) begin
          r_count <= r_count - 1'b1;
        end
        if (w_fault_go) begin
          r_fault_pc <= r_pc;
        end
      end
    end
  end

  // Queue storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_tail] <= bus.imem_data;
      r_q_pc[r_tail]    <= r_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational ROM model.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [63:0] last_pc;

  instr_fetch_unit_if bus_if ();

  instr_fetch_unit #(
    .DEPTH(4),
    .MEM_SIZE(1024),
    .RESET_PC(64'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  function automatic logic [31:0] rom(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  assign bus_if.imem_data = rom(bus_if.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 64'd0;
    bus_if.out_ready      = 1'b0;
    step();
    step();

    chk("rst_valid",    64'(bus_if.out_valid), 64'd0);
    chk("rst_instr",    64'(bus_if.out_instr), 64'd0);
    chk("rst_pc",       bus_if.out_pc, 64'd0);
    chk("rst_fault",    64'(bus_if.fault), 64'd0);
    chk("rst_fault_pc", bus_if.fault_pc, 64'd0);
    chk("rst_addr",     bus_if.imem_addr, 64'd0);

    // 1: streaming from reset
    bus_if.out_ready = 1'b1;
    reset = 1'b0;
    step();
    chk("t1_valid", 64'(bus_if.out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pc",    bus_if.out_pc, 64'(4 * i));
      chk("t1_instr", 64'(bus_if.out_instr), 64'(rom(64'(4 * i))));
      step();
    end

    // 2: backpressure fills the queue, then drains without gaps
    do_reset();
    bus_if.out_ready = 1'b0;
    repeat (10) step();
    chk("t2_addr_hold", bus_if.imem_addr, 64'd16);
    chk("t2_head_pc",   bus_if.out_pc, 64'd0);
    chk("t2_valid",     64'(bus_if.out_valid), 64'd1);
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_d", 64'(bus_if.out_valid), 64'd1);
      chk("t2_pc",      bus_if.out_pc, 64'(4 * i));
      chk("t2_instr",   64'(bus_if.out_instr), 64'(rom(64'(4 * i))));
      step();
    end

    // 3: redirect with three entries queued and head being consumed
    do_reset();
    bus_if.out_ready = 1'b0;
    repeat (3) step();
    chk("t3_addr_pre", bus_if.imem_addr, 64'd12);
    bus_if.out_ready      = 1'b1;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h40;
    chk("t3_head", bus_if.out_pc, 64'd0);
    step();
    bus_if.redirect_valid = 1'b0;
    chk("t3_flush_valid", 64'(bus_if.out_valid), 64'd0);
    chk("t3_addr",        bus_if.imem_addr, 64'h40);
    step();
    chk("t3_valid", 64'(bus_if.out_valid), 64'd1);
    chk("t3_pc0",   bus_if.out_pc, 64'h40);
    step();
    chk("t3_pc1",   bus_if.out_pc, 64'h44);

    // 4: run off the end of the ROM
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'd1000;
    step();
    bus_if.redirect_valid = 1'b0;
    last_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.out_valid) last_pc = bus_if.out_pc;
      if (bus_if.fault) break;
      step();
    end
    chk("t4_fault",    64'(bus_if.fault), 64'd1);
    chk("t4_fault_pc", bus_if.fault_pc, 64'd1024);
    chk("t4_last_pc",  last_pc, 64'd1020);
    repeat (3) step();
    chk("t4_drained",  64'(bus_if.out_valid), 64'd0);
    chk("t4_pc_held",  bus_if.imem_addr, 64'd1024);
    chk("t4_sticky",   64'(bus_if.fault), 64'd1);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'd0;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("t4_clear", 64'(bus_if.fault), 64'd0);
    step();
    chk("t4_valid", 64'(bus_if.out_valid), 64'd1);
    chk("t4_pc",    bus_if.out_pc, 64'd0);

    // 5: misaligned redirect target
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'h42;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("t5_no_fault_yet", 64'(bus_if.fault), 64'd0);
    step();
    chk("t5_fault",    64'(bus_if.fault), 64'd1);
    chk("t5_fault_pc", bus_if.fault_pc, 64'h42);
    chk("t5_valid",    64'(bus_if.out_valid), 64'd0);

    // 6: async reset mid-stream
    bus_if.out_ready      = 1'b0;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 64'd0;
    step();
    bus_if.redirect_valid = 1'b0;
    repeat (3) step();
    chk("t6_pre_valid", 64'(bus_if.out_valid), 64'd1);
    chk("t6_pre_addr",  bus_if.imem_addr, 64'd12);
    chk("t6_pre_fault", 64'(bus_if.fault), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 64'(bus_if.out_valid), 64'd0);
    chk("t6_async_addr",  bus_if.imem_addr, 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("t6_resume_valid", 64'(bus_if.out_valid), 64'd1);
    chk("t6_resume_pc",    bus_if.out_pc, 64'd0);
    chk("t6_resume_addr",  bus_if.imem_addr, 64'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
